// File: rtl/rgb_ycc_processing.sv
// Streaming RGB -> YCbCr (Q10.8) converter with a second stage that rebuilds clamped 8-bit RGB.
// The pipeline advances only on iValid. Per-stream counters raise done flags after one full frame.
module rgb_ycc_processing #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               iValid,
  input  logic [23:0]        iData,
  output logic signed [17:0] y,
  output logic signed [17:0] cb,
  output logic signed [17:0] cr,
  output logic               yccValid,
  output logic               yccDone,
  output logic [23:0]        oData,
  output logic               oValid,
  output logic               oDone
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int CW = $clog2(N + 1);
  typedef logic [CW-1:0] cnt_t;

  function automatic logic signed [17:0] mul8(input logic [7:0] c, input int k);
    return 18'(k * int'(c));
  endfunction

  function automatic logic signed [27:0] mul18(input logic signed [17:0] v, input int k);
    return 28'(k * int'(v));
  endfunction

  function automatic logic [7:0] clamp8(input logic signed [27:0] v);
    logic signed [27:0] t;
    t = (v + 28'sd128) >>> 8;
    if (t < 0)          return 8'd0;
    if (t > 28'sd255)   return 8'hFF;
    return t[7:0];
  endfunction

  cnt_t in_cnt, ycc_cnt, o_cnt;

  logic [7:0]        s1_r, s1_g, s1_b;
  logic              s1_v;
  logic signed [17:0] p_yr, p_yg, p_yb, p_br, p_bg, p_bb, p_rr, p_rg, p_rb;
  logic              s2_v;
  logic              s3_v;
  logic signed [17:0] s4_y;
  logic signed [27:0] q_r, q_gb, q_gr, q_b;
  logic              s4_v;
  logic signed [27:0] s5_r, s5_g, s5_b;
  logic              s5_v;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_cnt   <= '0;
      ycc_cnt  <= '0;
      o_cnt    <= '0;
      s1_r     <= '0;
      s1_g     <= '0;
      s1_b     <= '0;
      s1_v     <= 1'b0;
      p_yr     <= '0;
      p_yg     <= '0;
      p_yb     <= '0;
      p_br     <= '0;
      p_bg     <= '0;
      p_bb     <= '0;
      p_rr     <= '0;
      p_rg     <= '0;
      p_rb     <= '0;
      s2_v     <= 1'b0;
      y        <= '0;
      cb       <= '0;
      cr       <= '0;
      s3_v     <= 1'b0;
      s4_y     <= '0;
      q_r      <= '0;
      q_gb     <= '0;
      q_gr     <= '0;
      q_b      <= '0;
      s4_v     <= 1'b0;
      s5_r     <= '0;
      s5_g     <= '0;
      s5_b     <= '0;
      s5_v     <= 1'b0;
      oData    <= '0;
      yccValid <= 1'b0;
      yccDone  <= 1'b0;
      oValid   <= 1'b0;
      oDone    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage read its predecessor's pre-edge value,
      // so the stage order written here does not matter.
      yccValid <= 1'b0;
      oValid   <= 1'b0;
      if (iValid) begin
        // Past the frame size the input keeps advancing but only injects bubbles.
        s1_v <= (in_cnt < cnt_t'(N));
        if (in_cnt < cnt_t'(N)) in_cnt <= in_cnt + 1'b1;
        {s1_r, s1_g, s1_b} <= iData;

        p_yr <= mul8(s1_r, 77);
        p_yg <= mul8(s1_g, 150);
        p_yb <= mul8(s1_b, 29);
        p_br <= mul8(s1_r, -43);
        p_bg <= mul8(s1_g, -85);
        p_bb <= mul8(s1_b, 128);
        p_rr <= mul8(s1_r, 128);
        p_rg <= mul8(s1_g, -107);
        p_rb <= mul8(s1_b, -21);
        s2_v <= s1_v;

        y        <= p_yr + p_yg + p_yb;
        cb       <= p_br + p_bg + p_bb;
        cr       <= p_rr + p_rg + p_rb;
        s3_v     <= s2_v;
        yccValid <= s2_v;
        if (s2_v) begin
          ycc_cnt <= ycc_cnt + 1'b1;
          if (ycc_cnt == cnt_t'(N - 1)) yccDone <= 1'b1;
        end

        s4_y <= y;
        q_r  <= mul18(cr, 359);
        q_gb <= mul18(cb, 88);
        q_gr <= mul18(cr, 183);
        q_b  <= mul18(cb, 454);
        s4_v <= s3_v;

        s5_r <= 28'(s4_y) + (q_r >>> 8);
        s5_g <= 28'(s4_y) - ((q_gb + q_gr) >>> 8);
        s5_b <= 28'(s4_y) + (q_b >>> 8);
        s5_v <= s4_v;

        oData  <= {clamp8(s5_r), clamp8(s5_g), clamp8(s5_b)};
        oValid <= s5_v;
        if (s5_v) begin
          o_cnt <= o_cnt + 1'b1;
          if (o_cnt == cnt_t'(N - 1)) oDone <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb_ycc_processing.sv
// Self-checking bench for rgb_ycc_processing on a reduced frame size.
// Uses directed table vectors, then random streams with stalls checked by an arithmetic scoreboard.
module tb_rgb_ycc_processing;

  localparam int TW = 16;
  localparam int TH = 12;
  localparam int N  = TW * TH;

  logic               clk = 1'b0;
  logic               reset;
  logic               iValid;
  logic [23:0]        iData;
  logic signed [17:0] y, cb, cr;
  logic               yccValid, yccDone, oValid, oDone;
  logic [23:0]        oData;

  rgb_ycc_processing #(.WIDTH(TW), .HEIGHT(TH)) dut (
    .clk(clk), .reset(reset), .iValid(iValid), .iData(iData),
    .y(y), .cb(cb), .cr(cr), .yccValid(yccValid), .yccDone(yccDone),
    .oData(oData), .oValid(oValid), .oDone(oDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] pix;
    int          ey, ecb, ecr;
    logic [23:0] ergb;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [23:0] in_q[$];
  logic [23:0] rgb_q[$];
  int acc_cnt, ycc_pulses, o_pulses, adv_cnt, ycc_mark;
  bit o_done_seen;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Floor division by 256 written with plain integer arithmetic.
  function automatic int fdiv256(input int v);
    if (v >= 0) return v / 256;
    return -((-v + 255) / 256);
  endfunction

  function automatic int clamp255(input int v);
    if (v < 0)   return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  task automatic ycc_model(input logic [23:0] p, output int yy, output int cbv, output int crv);
    int r, g, b;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    yy  = 77 * r + 150 * g + 29 * b;
    cbv = -43 * r - 85 * g + 128 * b;
    crv = 128 * r - 107 * g - 21 * b;
  endtask

  function automatic logic [23:0] rgb_model(input int yy, input int cbv, input int crv);
    int r, g, b;
    r = clamp255(fdiv256(yy + fdiv256(359 * crv) + 128));
    g = clamp255(fdiv256(yy - fdiv256(88 * cbv + 183 * crv) + 128));
    b = clamp255(fdiv256(yy + fdiv256(454 * cbv) + 128));
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  task automatic clear_model();
    in_q.delete();
    rgb_q.delete();
    acc_cnt     = 0;
    ycc_pulses  = 0;
    o_pulses    = 0;
    adv_cnt     = 0;
    ycc_mark    = -1;
    o_done_seen = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_y"}, y, 0);
    check({tag, "_cb"}, cb, 0);
    check({tag, "_cr"}, cr, 0);
    check({tag, "_yccvalid"}, yccValid, 0);
    check({tag, "_yccdone"}, yccDone, 0);
    check({tag, "_odata"}, oData, 0);
    check({tag, "_ovalid"}, oValid, 0);
    check({tag, "_odone"}, oDone, 0);
  endtask

  // One clock: drive, advance, then sample 1 time unit after the edge and score outputs.
  task automatic cycle(input logic v, input logic [23:0] d);
    longint py, pcb, pcr, pod;
    logic [23:0] p;
    int ey, ecb, ecr;
    py = y; pcb = cb; pcr = cr; pod = oData;
    iValid = v;
    iData  = d;
    if (v && acc_cnt < N) begin
      in_q.push_back(d);
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    if (v) adv_cnt++;
    if (!v) begin
      check("stall_yccvalid", yccValid, 0);
      check("stall_ovalid", oValid, 0);
      check("stall_hold_y", y, py);
      check("stall_hold_cb", cb, pcb);
      check("stall_hold_cr", cr, pcr);
      check("stall_hold_odata", oData, pod);
    end
    if (yccValid) begin
      ycc_pulses++;
      check("ycc_pulse_has_pixel", in_q.size() > 0, 1);
      if (in_q.size() > 0) begin
        p = in_q.pop_front();
        ycc_model(p, ey, ecb, ecr);
        check("sb_y", y, ey);
        check("sb_cb", cb, ecb);
        check("sb_cr", cr, ecr);
        rgb_q.push_back(p);
      end
    end
    if (oValid) begin
      o_pulses++;
      check("rgb_pulse_has_pixel", rgb_q.size() > 0, 1);
      if (rgb_q.size() > 0) begin
        p = rgb_q.pop_front();
        ycc_model(p, ey, ecb, ecr);
        check("sb_odata", oData, rgb_model(ey, ecb, ecr));
      end
    end
    check("ycc_done_flag", yccDone, ycc_pulses >= N);
    check("o_done_flag", oDone, o_pulses >= N);
    if (yccDone && ycc_mark < 0) ycc_mark = adv_cnt;
    if (oDone && !o_done_seen) begin
      o_done_seen = 1'b1;
      check("odone_after_yccdone_edges", adv_cnt - ycc_mark, 3);
    end
  endtask

  task automatic pulse_reset();
    #2;
    reset = 1'b0;
    #1;
    check_zero("async_reset");
    iValid = 1'b0;
    repeat (2) @(posedge clk);
    clear_model();
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic run_frame(input int gap_pct, input int flush_cycles);
    int n;
    bit v;
    n = 0;
    while (n < N) begin
      v = ($urandom_range(0, 99) >= gap_pct);
      cycle(v, $urandom);
      if (v) n++;
    end
    for (int i = 0; i < flush_cycles; i++) cycle(1'b1, $urandom);
    check("frame_ycc_pulses", ycc_pulses, N);
    check("frame_rgb_pulses", o_pulses, N);
    check("frame_ycc_queue_drained", in_q.size(), 0);
    check("frame_rgb_queue_drained", rgb_q.size(), 0);
    check("frame_yccdone", yccDone, 1);
    check("frame_odone", oDone, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[4];
    tbl[0] = '{pix: 24'hFFFFFF, ey: 65280, ecb: 0,      ecr: 0,      ergb: 24'hFFFFFF};
    tbl[1] = '{pix: 24'hFF0000, ey: 19635, ecb: -10965, ecr: 32640,  ergb: 24'hFF0001};
    tbl[2] = '{pix: 24'h000000, ey: 0,     ecb: 0,      ecr: 0,      ergb: 24'h000000};
    tbl[3] = '{pix: 24'h0000FF, ey: 7395,  ecb: 32640,  ecr: -5355,  ergb: 24'h0000FF};

    reset  = 1'b0;
    iValid = 1'b0;
    iData  = '0;
    clear_model();
    #22;
    check_zero("reset_held");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b0, $urandom);
    check_zero("after_release");

    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, tbl[i].pix);
      if (i == 0) check("latency_ycc_edge1", yccValid, 0);
      for (int k = 1; k <= 5; k++) begin
        cycle(1'b1, 24'h000000);
        if (i == 0 && k == 1) check("latency_ycc_edge2", yccValid, 0);
        if (i == 0 && k == 4) check("latency_rgb_edge5", oValid, 0);
        if (k == 2) begin
          check("tbl_yccvalid", yccValid, 1);
          check("tbl_y", y, tbl[i].ey);
          check("tbl_cb", cb, tbl[i].ecb);
          check("tbl_cr", cr, tbl[i].ecr);
        end
        if (k == 5) begin
          check("tbl_ovalid", oValid, 1);
          check("tbl_odata", oData, tbl[i].ergb);
        end
      end
    end

    pulse_reset();
    run_frame(25, 40);

    pulse_reset();
    for (int i = 0; i < 100; i++) cycle(1'b1, $urandom);
    pulse_reset();
    check_zero("after_midframe_reset");
    run_frame(0, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
